// File: rtl/ctrl_pkg.sv
// Shared encodings for the gen2 control unit: state codes, opcodes,
// accumulator source / ALU operation selects and the default wait timeout.
package ctrl_pkg;

  typedef enum logic [3:0] {
    ST_START  = 4'h0,
    ST_FETCH  = 4'h1,
    ST_DECODE = 4'h2,
    ST_ERROR  = 4'h3,
    ST_JMP    = 4'h4,
    ST_LOAD   = 4'h8,
    ST_STORE  = 4'h9,
    ST_ALU    = 4'hA,
    ST_INPUT  = 4'hC,
    ST_JZ     = 4'hD,
    ST_JPOS   = 4'hE,
    ST_HALT   = 4'hF
  } state_e;

  localparam logic [3:0] OP_LOAD  = 4'h0;
  localparam logic [3:0] OP_STORE = 4'h1;
  localparam logic [3:0] OP_ADD   = 4'h2;
  localparam logic [3:0] OP_SUB   = 4'h3;
  localparam logic [3:0] OP_INPUT = 4'h4;
  localparam logic [3:0] OP_JZ    = 4'h5;
  localparam logic [3:0] OP_JPOS  = 4'h6;
  localparam logic [3:0] OP_HALT  = 4'h7;
  localparam logic [3:0] OP_AND   = 4'h8;
  localparam logic [3:0] OP_OR    = 4'h9;
  localparam logic [3:0] OP_JMP   = 4'hA;

  localparam logic [1:0] ASEL_ALU   = 2'b00;
  localparam logic [1:0] ASEL_ENTER = 2'b01;
  localparam logic [1:0] ASEL_MEM   = 2'b10;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_OR  = 2'b11;

  localparam int WAIT_MAX_DEF = 15;

endpackage

// File: rtl/enter_latch.sv
// Operator Enter key capture: two-flop synchroniser, rising-edge detect and a
// pending flag held until the FSM consumes it.
module enter_latch (
  input  logic clk,
  input  logic reset,
  input  logic enter,
  input  logic consume,
  output logic pending
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic prev_q, prev_d;
  logic pend_q, pend_d;
  logic rise;

  always_comb begin
    sync1_d = enter;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
    rise    = sync2_q & ~prev_q;
    // A fresh edge wins over a same-cycle consume so no keypress is lost.
    pend_d  = rise | (pend_q & ~consume);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
      pend_q  <= pend_d;
    end
  end

  assign pending = pend_q;

endmodule

// File: rtl/ctrl_unit_gen2.sv
// Multi-cycle control FSM for the accumulator CPU: fetch/decode/execute with
// memory-wait timeout, operator Enter handshake and instruction counter.
module ctrl_unit_gen2
  import ctrl_pkg::*;
#(
  parameter int IR_W     = 4,
  parameter int WAIT_MAX = WAIT_MAX_DEF
) (
  input  logic            CLOCK_50,
  input  logic            reset,
  input  logic            step_en,
  input  logic            Enter,
  input  logic [IR_W-1:0] IR,
  input  logic            Aeq0,
  input  logic            Apos,
  input  logic            mem_ready,
  output logic            IRload,
  output logic            PCload,
  output logic            Aload,
  output logic            MemWr,
  output logic            JMPmux,
  output logic            Meminst,
  output logic            Sub,
  output logic            Halt,
  output logic            mem_req,
  output logic            mem_err,
  output logic [1:0]      Asel,
  output logic [1:0]      AluOp,
  output logic [3:0]      DisplayState,
  output logic [15:0]     instr_count
);

  localparam logic [7:0] WAIT_LIM = 8'(WAIT_MAX);

  state_e      state_q, state_d;
  logic [7:0]  wait_q, wait_d, wait_inc;
  logic [15:0] instr_count_q, instr_count_d;
  logic [3:0]  op;
  logic        pending, consume, waiting;

  enter_latch u_enter (
    .clk     (CLOCK_50),
    .reset   (reset),
    .enter   (Enter),
    .consume (consume),
    .pending (pending)
  );

  assign op       = 4'(IR);
  assign wait_inc = wait_q + 8'd1;

  always_comb begin
    state_d = state_q;
    IRload  = 1'b0;
    PCload  = 1'b0;
    Aload   = 1'b0;
    MemWr   = 1'b0;
    JMPmux  = 1'b0;
    Meminst = 1'b0;
    Halt    = 1'b0;
    mem_req = 1'b0;
    mem_err = 1'b0;
    Asel    = ASEL_ALU;
    AluOp   = ALU_ADD;
    consume = 1'b0;
    waiting = 1'b0;
    unique case (state_q)
      ST_START: if (step_en) state_d = ST_FETCH;
      ST_FETCH: begin
        mem_req = 1'b1;
        if (step_en && mem_ready) begin
          IRload  = 1'b1;
          PCload  = 1'b1;
          state_d = ST_DECODE;
        end else if (step_en) waiting = 1'b1;
      end
      ST_DECODE: begin
        Meminst = 1'b1;
        if (step_en) begin
          case (op)
            OP_LOAD:                        state_d = ST_LOAD;
            OP_STORE:                       state_d = ST_STORE;
            OP_ADD, OP_SUB, OP_AND, OP_OR:  state_d = ST_ALU;
            OP_INPUT:                       state_d = ST_INPUT;
            OP_JZ:                          state_d = ST_JZ;
            OP_JPOS:                        state_d = ST_JPOS;
            OP_HALT:                        state_d = ST_HALT;
            OP_JMP:                         state_d = ST_JMP;
            default:                        state_d = ST_ERROR;
          endcase
        end
      end
      ST_LOAD, ST_STORE, ST_ALU: begin
        mem_req = 1'b1;
        if (state_q == ST_LOAD) Asel = ASEL_MEM;
        if (state_q == ST_STORE) Meminst = 1'b1;
        if (state_q == ST_ALU) begin
          case (op)
            OP_SUB:  AluOp = ALU_SUB;
            OP_AND:  AluOp = ALU_AND;
            OP_OR:   AluOp = ALU_OR;
            default: AluOp = ALU_ADD;
          endcase
        end
        if (step_en && mem_ready) begin
          if (state_q == ST_STORE) MemWr = 1'b1;
          else                     Aload = 1'b1;
          state_d = ST_START;
        end else if (step_en) waiting = 1'b1;
      end
      ST_INPUT: begin
        Asel = ASEL_ENTER;
        if (step_en && pending) begin
          Aload   = 1'b1;
          consume = 1'b1;
          state_d = ST_START;
        end
      end
      ST_JZ, ST_JPOS, ST_JMP: begin
        JMPmux = 1'b1;
        if (step_en) begin
          PCload  = (state_q == ST_JMP) | ((state_q == ST_JZ) & Aeq0) |
                    ((state_q == ST_JPOS) & Apos);
          state_d = ST_START;
        end
      end
      ST_HALT: begin
        Halt = 1'b1;
        if (step_en && pending) begin
          consume = 1'b1;
          state_d = ST_START;
        end
      end
      ST_ERROR: begin
        Halt    = 1'b1;
        mem_err = 1'b1;
      end
      default: state_d = ST_ERROR;
    endcase
    if (waiting && wait_inc >= WAIT_LIM) state_d = ST_ERROR;
    // A reset edge abandons whatever is in flight, so no strobe may escape.
    if (!reset) begin
      IRload  = 1'b0;
      PCload  = 1'b0;
      Aload   = 1'b0;
      MemWr   = 1'b0;
      consume = 1'b0;
    end
    Sub = (AluOp == ALU_SUB);
  end

  always_comb begin
    wait_d = wait_q;
    if (state_d != state_q) wait_d = '0;
    else if (waiting)       wait_d = wait_inc;
    instr_count_d = instr_count_q;
    if (state_d == ST_START &&
        !(state_q inside {ST_START, ST_FETCH, ST_DECODE, ST_ERROR}))
      instr_count_d = instr_count_q + 16'd1;
  end

  always_ff @(posedge CLOCK_50) begin
    if (!reset) begin
      state_q       <= ST_START;
      wait_q        <= '0;
      instr_count_q <= '0;
    end else begin
      state_q       <= state_d;
      wait_q        <= wait_d;
      instr_count_q <= instr_count_d;
    end
  end

  assign DisplayState = state_q;
  assign instr_count  = instr_count_q;

endmodule

// File: tb/tb_ctrl_unit_gen2.sv
// Directed bench for ctrl_unit_gen2 (IR_W=4, WAIT_MAX=3): walks each
// instruction class, Enter handshake, timeout, illegal opcode and reset.
module tb_ctrl_unit_gen2;

  logic        clk = 1'b0;
  logic        reset, step_en, Enter, Aeq0, Apos, mem_ready;
  logic [3:0]  IR;
  logic        IRload, PCload, Aload, MemWr, JMPmux, Meminst, Sub, Halt;
  logic        mem_req, mem_err;
  logic [1:0]  Asel, AluOp;
  logic [3:0]  DisplayState;
  logic [15:0] instr_count;
  logic [33:0] all_out;

  int vectors = 0;
  int miscompares = 0;

  ctrl_unit_gen2 #(.IR_W(4), .WAIT_MAX(3)) dut (
    .CLOCK_50(clk), .reset(reset), .step_en(step_en), .Enter(Enter), .IR(IR),
    .Aeq0(Aeq0), .Apos(Apos), .mem_ready(mem_ready),
    .IRload(IRload), .PCload(PCload), .Aload(Aload), .MemWr(MemWr),
    .JMPmux(JMPmux), .Meminst(Meminst), .Sub(Sub), .Halt(Halt),
    .mem_req(mem_req), .mem_err(mem_err), .Asel(Asel), .AluOp(AluOp),
    .DisplayState(DisplayState), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  assign all_out = {IRload, PCload, Aload, MemWr, JMPmux, Meminst, Sub, Halt,
                    mem_req, mem_err, Asel, AluOp, DisplayState, instr_count};

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    assert (got === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic begin_step(input logic rdy);
    @(negedge clk);
    step_en   = 1'b1;
    mem_ready = rdy;
    #1;
  endtask

  task automatic end_step();
    @(posedge clk);
    #1;
    step_en   = 1'b0;
    mem_ready = 1'b0;
  endtask

  task automatic step(input logic rdy);
    begin_step(rdy);
    end_step();
  endtask

  task automatic go_to_decode(input logic [3:0] opcode);
    IR = opcode;
    step(1'b0);
    step(1'b1);
  endtask

  task automatic pulse_enter();
    @(negedge clk);
    Enter = 1'b1;
    repeat (4) @(negedge clk);
    Enter = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset     = 1'b0;
    step_en   = 1'b1;
    mem_ready = 1'b1;
    @(posedge clk);
    #1;
    reset     = 1'b1;
    step_en   = 1'b0;
    mem_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b0; step_en = 1'b0; Enter = 1'b0; IR = 4'h0;
    Aeq0 = 1'b0; Apos = 1'b0; mem_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_all_outputs", 64'(all_out), 64'h0);
    @(negedge clk);
    reset = 1'b1;

    // LOAD: two wait steps then ready
    IR = 4'h0;
    step(1'b0);
    chk("start_to_fetch", DisplayState, 4'h1);
    chk("fetch_mem_req", mem_req, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    chk("fetch_idle_hold", DisplayState, 4'h1);
    begin_step(1'b1);
    chk("fetch_irload_pcload", {IRload, PCload}, 2'b11);
    end_step();
    chk("decode_state", DisplayState, 4'h2);
    chk("decode_meminst", Meminst, 1'b1);
    step(1'b0);
    chk("load_state", DisplayState, 4'h8);
    chk("load_asel", Asel, 2'b10);
    begin_step(1'b0);
    chk("load_wait1_aload", Aload, 1'b0);
    end_step();
    begin_step(1'b0);
    chk("load_wait2_aload", Aload, 1'b0);
    end_step();
    chk("load_still_waiting", DisplayState, 4'h8);
    begin_step(1'b1);
    chk("load_aload", Aload, 1'b1);
    end_step();
    chk("load_aload_gone", Aload, 1'b0);
    chk("load_done_start", DisplayState, 4'h0);
    chk("count_after_load", instr_count, 16'd1);

    // ALU sub, then ALU or
    go_to_decode(4'h3);
    step(1'b0);
    chk("alu_state", DisplayState, 4'hA);
    chk("sub_aluop_sub", {AluOp, Sub}, 3'b011);
    begin_step(1'b1);
    chk("sub_aload", Aload, 1'b1);
    end_step();
    go_to_decode(4'h9);
    step(1'b0);
    chk("or_aluop_sub", {AluOp, Sub}, 3'b110);
    step(1'b1);
    chk("count_after_alu", instr_count, 16'd3);

    // JZ not taken, then taken
    go_to_decode(4'h5);
    step(1'b0);
    chk("jz_state_jmpmux", {DisplayState, JMPmux}, 5'b1101_1);
    Aeq0 = 1'b0;
    begin_step(1'b0);
    chk("jz_not_taken", {PCload, JMPmux}, 2'b01);
    end_step();
    go_to_decode(4'h5);
    step(1'b0);
    Aeq0 = 1'b1;
    #1;
    chk("jz_no_step_no_pcload", PCload, 1'b0);
    begin_step(1'b0);
    chk("jz_taken", {PCload, JMPmux}, 2'b11);
    end_step();
    Aeq0 = 1'b0;
    chk("count_after_jz", instr_count, 16'd5);

    // INPUT waits for Enter
    go_to_decode(4'h4);
    step(1'b0);
    chk("input_asel", {DisplayState, Asel}, 6'b1100_01);
    for (int i = 0; i < 5; i++) begin
      begin_step(1'b0);
      chk("input_no_enter_aload", Aload, 1'b0);
      end_step();
    end
    chk("input_holds", DisplayState, 4'hC);
    pulse_enter();
    chk("input_no_step_hold", DisplayState, 4'hC);
    begin_step(1'b0);
    chk("input_aload", Aload, 1'b1);
    end_step();
    chk("input_to_start", DisplayState, 4'h0);
    chk("count_after_input", instr_count, 16'd6);
    go_to_decode(4'h4);
    step(1'b0);
    begin_step(1'b0);
    chk("pending_consumed", Aload, 1'b0);
    end_step();
    pulse_enter();
    step(1'b0);
    chk("count_after_input2", instr_count, 16'd7);

    // JPOS and JMP
    go_to_decode(4'h6);
    step(1'b0);
    Apos = 1'b1;
    begin_step(1'b0);
    chk("jpos_taken", {DisplayState, PCload, JMPmux}, 6'b1110_11);
    end_step();
    Apos = 1'b0;
    go_to_decode(4'hA);
    step(1'b0);
    begin_step(1'b0);
    chk("jmp_taken", {DisplayState, PCload, JMPmux}, 6'b0100_11);
    end_step();
    chk("count_after_jumps", instr_count, 16'd9);

    // Illegal opcode
    go_to_decode(4'hC);
    step(1'b0);
    chk("illegal_error", {DisplayState, Halt}, 5'b0011_1);
    step(1'b1);
    chk("illegal_sticky", DisplayState, 4'h3);
    chk("illegal_count_kept", instr_count, 16'd9);
    do_reset();
    chk("reset_from_error", 64'(all_out), 64'h0);

    // HALT released by Enter
    go_to_decode(4'h7);
    step(1'b0);
    chk("halt_state", {DisplayState, Halt}, 5'b1111_1);
    step(1'b0);
    chk("halt_waits", DisplayState, 4'hF);
    pulse_enter();
    begin_step(1'b0);
    chk("halt_no_pcload", PCload, 1'b0);
    end_step();
    chk("halt_to_start", DisplayState, 4'h0);
    chk("count_after_halt", instr_count, 16'd1);

    // ALU add with memory never ready -> timeout
    go_to_decode(4'h2);
    step(1'b0);
    chk("add_aluop", {DisplayState, AluOp, Sub}, 7'b1010_00_0);
    step(1'b0);
    step(1'b0);
    chk("timeout_not_yet", DisplayState, 4'hA);
    step(1'b0);
    chk("timeout_error", {DisplayState, mem_err, Halt}, 6'b0011_11);
    step(1'b1);
    chk("timeout_sticky", {DisplayState, mem_err, Halt}, 6'b0011_11);
    chk("timeout_count_kept", instr_count, 16'd1);
    do_reset();
    chk("reset_clears_err", 64'(all_out), 64'h0);

    // Reset in INPUT with Enter pending
    go_to_decode(4'h4);
    step(1'b0);
    pulse_enter();
    @(negedge clk);
    reset   = 1'b0;
    step_en = 1'b1;
    #1;
    chk("reset_blocks_aload", Aload, 1'b0);
    @(posedge clk);
    #1;
    reset   = 1'b1;
    step_en = 1'b0;
    chk("reset_mid_input", {DisplayState, instr_count}, 20'h0);
    go_to_decode(4'h4);
    step(1'b0);
    begin_step(1'b0);
    chk("reset_cleared_pending", Aload, 1'b0);
    end_step();
    chk("input_after_reset_holds", DisplayState, 4'hC);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
